// File: rtl/lsu_align.sv
// Load/store alignment unit: splits word-crossing accesses into two
// aligned word cycles, drives byte strobes and merges/extends load data.
module lsu_align #(
  parameter int ADDR_SIZE     = 32,
  parameter int WORD_LEN      = 32,
  parameter int MISALIGN_TRAP = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [2:0]           req_funct3,
  input  logic [WORD_LEN-1:0]  req_wdata,
  input  logic [ADDR_SIZE-1:0] req_pc,
  output logic                 resp_valid,
  output logic [WORD_LEN-1:0]  resp_rdata,
  output logic                 resp_fault,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [3:0]           mem_wstrb,
  output logic [WORD_LEN-1:0]  mem_wdata,
  input  logic [WORD_LEN-1:0]  mem_rdata,
  output logic [ADDR_SIZE-1:0] mem_pc,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    RESP
  } state_e;

  // Access size in bytes from the low funct3 bits.
  function automatic logic [2:0] size_of(input logic [1:0] f);
    logic [2:0] n;
    unique case (f)
      2'd0:    n = 3'd1;
      2'd1:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic illegal_of(input logic wr,
                                      input logic [2:0] f);
    if (wr) return f > 3'd2;
    return (f == 3'd3) || (f[2:1] == 2'b11);
  endfunction

  function automatic logic cross_of(input logic [1:0] off,
                                    input logic [2:0] n);
    return ({1'b0, off} + n) > 3'd4;
  endfunction

  state_e state_q, state_d;

  logic                 wr_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ADDR_SIZE-1:0] pc_q;
  logic [ADDR_SIZE-1:0] maddr_q;
  logic [2:0]           f3_q;
  logic [WORD_LEN-1:0]  wdata_q;
  logic [WORD_LEN-1:0]  lo_q;
  logic [WORD_LEN-1:0]  rdata_q;
  logic [WORD_LEN-1:0]  mwdata_q;
  logic                 fault_q;

  logic                 accept;
  logic                 fault_in;
  logic [2:0]           n_q;
  logic [1:0]           off_q;
  logic                 cross_q;
  logic                 acc;
  logic                 hi_acc;
  logic                 fin;
  logic [4:0]           sh;
  logic [ADDR_SIZE-1:0] word_q;
  logic [ADDR_SIZE-1:0] acc_addr;
  logic [WORD_LEN-1:0]  low;
  logic [2*WORD_LEN-1:0] lane;
  logic [7:0]           mask;
  logic [WORD_LEN-1:0]  acc_wdata;
  logic [2*WORD_LEN-1:0] cat;
  logic [WORD_LEN-1:0]  merged;
  logic [WORD_LEN-1:0]  ext;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = req_valid && req_ready;

  assign fault_in = illegal_of(req_write, req_funct3) ||
                    ((MISALIGN_TRAP != 0) &&
                     cross_of(req_addr[1:0],
                              size_of(req_funct3[1:0])));

  assign n_q     = size_of(f3_q[1:0]);
  assign off_q   = addr_q[1:0];
  assign cross_q = cross_of(off_q, n_q);
  assign acc     = (state_q == ACC0) || (state_q == ACC1);
  assign hi_acc  = (state_q == ACC1);
  assign fin     = acc && (state_d == RESP);
  assign sh      = {off_q, 3'b000};
  assign word_q  = {addr_q[ADDR_SIZE-1:2], 2'b00};
  assign acc_addr = hi_acc ? word_q + ADDR_SIZE'(4) : word_q;

  // Next-state sequencing of the access phases.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid) state_d = fault_in ? RESP : ACC0;
      ACC0: state_d = cross_q ? ACC1 : RESP;
      ACC1: state_d = RESP;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store lane placement: low n bytes shifted into a two-word window.
  always_comb begin
    unique case (n_q)
      3'd1:    low = WORD_LEN'(wdata_q[7:0]);
      3'd2:    low = WORD_LEN'(wdata_q[15:0]);
      default: low = wdata_q;
    endcase
    lane      = {{WORD_LEN{1'b0}}, low} << sh;
    mask      = ((8'd1 << n_q) - 8'd1) << off_q;
    acc_wdata = hi_acc ? lane[2*WORD_LEN-1:WORD_LEN]
                       : lane[WORD_LEN-1:0];
  end

  assign mem_we    = acc && wr_q;
  assign mem_wstrb = !mem_we ? 4'b0000
                   : hi_acc  ? mask[7:4] : mask[3:0];
  assign mem_addr  = acc ? acc_addr : maddr_q;
  assign mem_wdata = acc ? acc_wdata : mwdata_q;
  assign mem_pc    = busy ? pc_q : '0;

  // Load merge: {hi, lo} window shifted down by the byte offset.
  always_comb begin
    cat    = hi_acc ? {mem_rdata, lo_q}
                    : {{WORD_LEN{1'b0}}, mem_rdata};
    merged = cat[{1'b0, sh} +: WORD_LEN];
    unique case (f3_q)
      3'd0: ext = {{(WORD_LEN-8){merged[7]}}, merged[7:0]};
      3'd1: ext = {{(WORD_LEN-16){merged[15]}}, merged[15:0]};
      3'd4: ext = {{(WORD_LEN-8){1'b0}}, merged[7:0]};
      3'd5: ext = {{(WORD_LEN-16){1'b0}}, merged[15:0]};
      default: ext = merged;
    endcase
  end

  assign resp_valid = (state_q == RESP);
  assign resp_fault = resp_valid && fault_q;
  assign resp_rdata = rdata_q;

  // State, request latch, held memory bus and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      pc_q     <= '0;
      f3_q     <= '0;
      wdata_q  <= '0;
      fault_q  <= 1'b0;
      lo_q     <= '0;
      rdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        pc_q    <= req_pc;
        f3_q    <= req_funct3;
        wdata_q <= req_wdata;
        fault_q <= fault_in;
      end
      if (state_q == ACC0) lo_q <= mem_rdata;
      if (acc) begin
        maddr_q  <= acc_addr;
        mwdata_q <= acc_wdata;
      end
      rdata_q <= (fin && !wr_q) ? ext : '0;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed vector table, abort/trap sequences,
// and random traffic against a byte-level memory model.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_pc = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] mem_pc;
  logic        busy;

  logic        t_req_valid = 1'b0;
  logic        t_req_ready;
  logic        t_req_write = 1'b0;
  logic [31:0] t_req_addr = '0;
  logic [2:0]  t_req_funct3 = '0;
  logic [31:0] t_req_wdata = '0;
  logic [31:0] t_req_pc = '0;
  logic        t_resp_valid;
  logic [31:0] t_resp_rdata;
  logic        t_resp_fault;
  logic        t_mem_we;
  logic [31:0] t_mem_addr;
  logic [3:0]  t_mem_wstrb;
  logic [31:0] t_mem_wdata;
  logic [31:0] t_mem_rdata = '0;
  logic [31:0] t_mem_pc;
  logic        t_busy;

  lsu_align dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .req_pc(req_pc), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_pc(mem_pc), .busy(busy)
  );

  lsu_align #(.MISALIGN_TRAP(1)) dut_t (
    .clk(clk), .rst(rst),
    .req_valid(t_req_valid), .req_ready(t_req_ready),
    .req_write(t_req_write), .req_addr(t_req_addr),
    .req_funct3(t_req_funct3), .req_wdata(t_req_wdata),
    .req_pc(t_req_pc), .resp_valid(t_resp_valid),
    .resp_rdata(t_resp_rdata), .resp_fault(t_resp_fault),
    .mem_we(t_mem_we), .mem_addr(t_mem_addr),
    .mem_wstrb(t_mem_wstrb), .mem_wdata(t_mem_wdata),
    .mem_rdata(t_mem_rdata), .mem_pc(t_mem_pc), .busy(t_busy)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, exp);
    end
  endtask

  // Word memory seen by the DUT.
  logic [31:0] wmem [logic [31:0]];
  int          wr_cnt = 0;
  logic [31:0] wtmp;

  function automatic logic [31:0] rdw(input logic [31:0] a);
    if (wmem.exists(a)) return wmem[a];
    return 32'h0;
  endfunction

  always @(mem_addr or wr_cnt) mem_rdata = rdw(mem_addr);

  always @(posedge clk) begin
    if (mem_we) begin
      wtmp = rdw(mem_addr);
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) wtmp[8*b +: 8] = mem_wdata[8*b +: 8];
      wmem[mem_addr] = wtmp;
      wr_cnt++;
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    wmem[a] = d;
    wr_cnt++;
  endtask

  int t_we_cnt = 0;
  int resp_cnt = 0;
  always @(posedge clk) if (t_mem_we) t_we_cnt++;
  always @(negedge clk) if (resp_valid) resp_cnt++;

  // Byte-addressed reference memory for random traffic.
  logic [7:0] rmem [logic [31:0]];

  function automatic logic [7:0] rb(input logic [31:0] a);
    if (rmem.exists(a)) return rmem[a];
    return 8'h0;
  endfunction

  int          r_lat;
  int          r_we;
  logic [31:0] r_rdata;
  logic        r_fault;
  logic [31:0] s_addr  [1:3];
  logic [31:0] s_wdata [1:3];
  logic [31:0] s_pc    [1:3];
  logic [3:0]  s_strb  [1:3];

  task automatic run_req(input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] pc);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    req_pc = pc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    r_lat = 0;
    r_we = 0;
    r_rdata = '0;
    r_fault = 1'b0;
    for (int c = 1; c <= 8 && r_lat == 0; c++) begin
      @(negedge clk);
      if (c <= 3) begin
        s_addr[c]  = mem_addr;
        s_wdata[c] = mem_wdata;
        s_pc[c]    = mem_pc;
        s_strb[c]  = mem_wstrb;
      end
      if (mem_we) r_we++;
      if (resp_valid) begin
        r_lat = c;
        r_rdata = resp_rdata;
        r_fault = resp_fault;
      end
    end
    @(negedge clk);
    chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    chk("rdata_zero_after", resp_rdata, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        pre;
    logic [31:0] pa0, pd0, pa1, pd1;
    logic [31:0] xr;
    logic        xf;
    int          xl;
    logic [31:0] xa0;
    logic [3:0]  xs0;
    logic [31:0] xd0;
    logic [31:0] xa1;
    logic [3:0]  xs1;
    logic [31:0] xd1;
  } vec_t;

  function automatic vec_t mk(
    input logic wr, input logic [2:0] f3,
    input logic [31:0] addr, input logic [31:0] wd,
    input logic pre,
    input logic [31:0] pa0, input logic [31:0] pd0,
    input logic [31:0] pa1, input logic [31:0] pd1,
    input logic [31:0] xr, input logic xf, input int xl,
    input logic [31:0] xa0, input logic [3:0] xs0,
    input logic [31:0] xd0,
    input logic [31:0] xa1, input logic [3:0] xs1,
    input logic [31:0] xd1);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd;
    v.pre = pre; v.pa0 = pa0; v.pd0 = pd0;
    v.pa1 = pa1; v.pd1 = pd1;
    v.xr = xr; v.xf = xf; v.xl = xl;
    v.xa0 = xa0; v.xs0 = xs0; v.xd0 = xd0;
    v.xa1 = xa1; v.xs1 = xs1; v.xd1 = xd1;
    return v;
  endfunction

  vec_t vt [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(0, 2, 32'h10, 0, 1, 32'h10, 32'h11223344, 32'h14, 0,
                32'h11223344, 0, 2, 32'h10, 4'b0000, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 32'h13, 0, 1, 32'h10, 32'hAABBCCDD,
                32'h14, 32'h112233F4,
                32'hFFFFF4AA, 0, 3, 32'h10, 0, 0, 32'h14, 0, 0);
    vt[2]  = mk(0, 5, 32'h13, 0, 0, 0, 0, 0, 0,
                32'h0000F4AA, 0, 3, 32'h10, 0, 0, 32'h14, 0, 0);
    vt[3]  = mk(1, 2, 32'h22, 32'hDEADBEEF, 0, 0, 0, 0, 0,
                0, 0, 3, 32'h20, 4'b1100, 32'hBEEF0000,
                32'h24, 4'b0011, 32'h0000DEAD);
    vt[4]  = mk(0, 2, 32'h22, 0, 0, 0, 0, 0, 0,
                32'hDEADBEEF, 0, 3, 32'h20, 0, 0, 32'h24, 0, 0);
    vt[5]  = mk(0, 0, 32'h01, 0, 1, 32'h00, 32'h00008000, 32'h04, 0,
                32'hFFFFFF80, 0, 2, 32'h00, 0, 0, 0, 0, 0);
    vt[6]  = mk(0, 4, 32'h01, 0, 0, 0, 0, 0, 0,
                32'h00000080, 0, 2, 32'h00, 0, 0, 0, 0, 0);
    vt[7]  = mk(1, 0, 32'h03, 32'h5A, 0, 0, 0, 0, 0,
                0, 0, 2, 32'h00, 4'b1000, 32'h5A000000, 0, 0, 0);
    vt[8]  = mk(0, 2, 32'h01, 0, 1, 32'h00, 32'h5A008000,
                32'h04, 32'h00000077,
                32'h775A0080, 0, 3, 32'h00, 0, 0, 32'h04, 0, 0);
    vt[9]  = mk(1, 1, 32'h03, 32'h1234ABCD, 0, 0, 0, 0, 0,
                0, 0, 3, 32'h00, 4'b1000, 32'hCD000000,
                32'h04, 4'b0001, 32'h000000AB);
    vt[10] = mk(0, 3, 32'h40, 0, 0, 0, 0, 0, 0,
                0, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[11] = mk(1, 4, 32'h40, 32'hFFFF, 0, 0, 0, 0, 0,
                0, 1, 1, 0, 0, 0, 0, 0, 0);
    vt[12] = mk(0, 2, 32'h04, 0, 0, 0, 0, 0, 0,
                32'h000000AB, 0, 2, 32'h04, 0, 0, 0, 0, 0);
    vt[13] = mk(0, 2, 32'h00, 0, 0, 0, 0, 0, 0,
                32'hCD008000, 0, 2, 32'h00, 0, 0, 0, 0, 0);
    vt[14] = mk(0, 1, 32'h02, 0, 0, 0, 0, 0, 0,
                32'hFFFFCD00, 0, 2, 32'h00, 0, 0, 0, 0, 0);
    vt[15] = mk(0, 7, 32'h41, 0, 0, 0, 0, 0, 0,
                0, 1, 1, 0, 0, 0, 0, 0, 0);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_pc", mem_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      vec_t v;
      logic [31:0] pc;
      int xwe;
      v = vt[i];
      pc = 32'h1000 + 32'(i) * 4;
      if (v.pre) begin
        preload(v.pa0, v.pd0);
        preload(v.pa1, v.pd1);
      end
      run_req(v.wr, v.f3, v.addr, v.wd, pc);
      xwe = (v.wr && !v.xf) ? v.xl - 1 : 0;
      chk($sformatf("v%0d_latency", i), 32'(r_lat), 32'(v.xl));
      chk($sformatf("v%0d_rdata", i), r_rdata, v.xr);
      chk($sformatf("v%0d_fault", i), 32'(r_fault), 32'(v.xf));
      chk($sformatf("v%0d_we_cycles", i), 32'(r_we), 32'(xwe));
      chk($sformatf("v%0d_mem_pc", i), s_pc[1], pc);
      if (v.xl >= 2) begin
        chk($sformatf("v%0d_addr0", i), s_addr[1], v.xa0);
        chk($sformatf("v%0d_strb0", i), 32'(s_strb[1]), 32'(v.xs0));
        if (v.wr) chk($sformatf("v%0d_wdata0", i), s_wdata[1], v.xd0);
      end
      if (v.xl == 3) begin
        chk($sformatf("v%0d_addr1", i), s_addr[2], v.xa1);
        chk($sformatf("v%0d_strb1", i), 32'(s_strb[2]), 32'(v.xs1));
        if (v.wr) chk($sformatf("v%0d_wdata1", i), s_wdata[2], v.xd1);
      end
    end

    // Split store at the top of memory, reset during the second half.
    preload(32'h0, 32'h13579BDF);
    preload(32'hFFFFFFFC, 32'h0);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_funct3 = 3'd2;
    req_addr = 32'hFFFFFFFE;
    req_wdata = 32'hCAFEF00D;
    req_pc = 32'h2000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("ab_addr0", mem_addr, 32'hFFFFFFFC);
    chk("ab_we0", 32'(mem_we), 32'd1);
    chk("ab_strb0", 32'(mem_wstrb), 32'b1100);
    chk("ab_wdata0", mem_wdata, 32'hF00D0000);
    chk("ab_mem_pc", mem_pc, 32'h2000);
    @(negedge clk);
    chk("ab_addr1_wrap", mem_addr, 32'h0);
    chk("ab_strb1", 32'(mem_wstrb), 32'b0011);
    chk("ab_wdata1", mem_wdata, 32'h0000CAFE);
    begin
      int rc;
      rc = resp_cnt;
      rst = 1'b1;
      #1;
      chk("ab_we_drop", 32'(mem_we), 32'd0);
      chk("ab_busy_drop", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("ab_no_resp", 32'(resp_cnt - rc), 32'd0);
    end
    chk("ab_ready", 32'(req_ready), 32'd1);
    chk("ab_word0_kept", rdw(32'h0), 32'h13579BDF);
    chk("ab_top_written", rdw(32'hFFFFFFFC), 32'hF00D0000);

    // Trapping instance: crossing store faults, aligned one proceeds.
    t_we_cnt = 0;
    @(negedge clk);
    chk("t_ready", 32'(t_req_ready), 32'd1);
    t_req_valid = 1'b1;
    t_req_write = 1'b1;
    t_req_funct3 = 3'd2;
    t_req_addr = 32'h02;
    t_req_wdata = 32'h12345678;
    t_req_pc = 32'h3000;
    @(posedge clk);
    #1 t_req_valid = 1'b0;
    @(negedge clk);
    chk("t_resp_valid", 32'(t_resp_valid), 32'd1);
    chk("t_resp_fault", 32'(t_resp_fault), 32'd1);
    chk("t_resp_rdata", t_resp_rdata, 32'd0);
    chk("t_mem_pc", t_mem_pc, 32'h3000);
    @(negedge clk);
    chk("t_resp_pulse", 32'(t_resp_valid), 32'd0);
    chk("t_no_write", 32'(t_we_cnt), 32'd0);
    t_req_valid = 1'b1;
    t_req_addr = 32'h04;
    @(posedge clk);
    #1 t_req_valid = 1'b0;
    @(negedge clk);
    chk("t_al_we", 32'(t_mem_we), 32'd1);
    chk("t_al_addr", t_mem_addr, 32'h04);
    chk("t_al_strb", 32'(t_mem_wstrb), 32'hF);
    chk("t_al_wdata", t_mem_wdata, 32'h12345678);
    chk("t_al_busy", 32'(t_busy), 32'd1);
    @(negedge clk);
    chk("t_al_resp", 32'(t_resp_valid), 32'd1);
    chk("t_al_fault", 32'(t_resp_fault), 32'd0);

    // Random traffic against the byte-level model.
    for (int k = 0; k < 300; k++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a, wd, xr;
      int          n, xl;
      logic        ill;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = 32'h100 + 32'($urandom_range(0, 63));
      wd = $urandom;
      n  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      ill = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
      xr = 0;
      if (ill) xl = 1;
      else xl = (int'(a % 4) + n > 4) ? 3 : 2;
      if (!ill) begin
        if (wr) begin
          for (int i = 0; i < n; i++)
            rmem[a + 32'(i)] = wd[8*i +: 8];
        end else begin
          for (int i = 0; i < n; i++)
            xr = xr | (32'(rb(a + 32'(i))) << (8 * i));
          if (f3 == 3'd0 && xr[7]) xr = xr | 32'hFFFFFF00;
          if (f3 == 3'd1 && xr[15]) xr = xr | 32'hFFFF0000;
        end
      end
      run_req(wr, f3, a, wd, 32'h4000 + 32'(k));
      chk($sformatf("rnd%0d_latency", k), 32'(r_lat), 32'(xl));
      chk($sformatf("rnd%0d_fault", k), 32'(r_fault), 32'(ill));
      chk($sformatf("rnd%0d_rdata", k), r_rdata, xr);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store alignment unit between the pipeline MEM stage and the byte-addressed data memory.
- Takes one load/store request per handshake and, when an access crosses a 32-bit word boundary, splits it into two aligned word accesses.
- Drives the memory with word addresses plus byte strobes.
- Merges, shifts and sign/zero-extends load data, then returns one registered response.

Parameters:
ADDR_SIZE, 32, address width
WORD_LEN, 32, data width (fixed 32; strobe logic assumes 4 bytes)
MISALIGN_TRAP, 0, 1 = word-crossing accesses fault instead of being split

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept request
req_write  input  1  1 = store, 0 = load
req_addr  input  ADDR_SIZE  byte address
req_funct3  input  3  RV32 funct3: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu
req_wdata  input  WORD_LEN  store data (low bytes significant)
req_pc  input  ADDR_SIZE  PC of issuing instruction
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  WORD_LEN  extended load data (0 for stores/faults)
resp_fault  output  1  illegal funct3 or trapped misalignment
mem_we  output  1  memory write enable
mem_addr  output  ADDR_SIZE  word-aligned address, bits [1:0] = 0
mem_wstrb  output  4  byte write strobes
mem_wdata  output  WORD_LEN  lane-aligned write data
mem_rdata  input  WORD_LEN  combinational read of word at mem_addr
mem_pc  output  ADDR_SIZE  latched req_pc, for memory trace display
busy  output  1  state != IDLE

Behaviour:
- Reset: async on rst high. State = IDLE. All outputs 0 except req_ready = 1 and busy = 0. mem_we drops immediately.
- States: IDLE, ACC0, ACC1, RESP.
- Accept: req_valid && req_ready on the rising edge. req_ready = 1 only in IDLE. All request fields are latched at accept.
- Size: n = 1 (funct3 0/4), 2 (funct3 1/5), 4 (funct3 2).
- Offset: off = addr[1:0]. cross = off + n > 4.
- Illegal funct3:
  - Loads: 3, 6, 7.
  - Stores: anything other than 0, 1, 2.
- Fault: illegal funct3, or cross with MISALIGN_TRAP = 1. Transition IDLE -> RESP with resp_fault = 1. No memory cycle is issued.
- Otherwise IDLE -> ACC0. ACC0 -> ACC1 if cross, else -> RESP. ACC1 -> RESP. RESP -> IDLE.
- Latency from the accept edge:
  - Aligned (non-crossing) access: resp_valid in the 2nd cycle.
  - Split access: resp_valid in the 3rd cycle.
  - Fault: resp_valid in the 1st cycle.
- Memory addressing:
  - ACC0: mem_addr = {addr[31:2], 2'b00}.
  - ACC1: mem_addr = ACC0 address + 4, modulo 2^ADDR_SIZE (0xFFFFFFFC wraps to 0).
  - Outside ACC0/ACC1: mem_we = 0, mem_wstrb = 0, mem_addr and mem_wdata hold their last values.
- Store lanes:
  - lane64 = zero-extended low n bytes of wdata << (8*off).
  - mask8 = ((1 << n) - 1) << off.
  - ACC0: wdata = lane64[31:0], wstrb = mask8[3:0].
  - ACC1: wdata = lane64[63:32], wstrb = mask8[7:4].
  - mem_we = 1 throughout ACC0/ACC1 for stores. The write commits at the edge ending each access state.
- Load merge:
  - mem_rdata is captured at the end of ACC0 (lo) and at the end of ACC1 (hi; 0 if no ACC1).
  - data = ({hi, lo} >> (8*off))[8n-1:0].
  - funct3 0/1: sign-extend. 4/5: zero-extend. 2: as is.
  - resp_rdata is registered and valid only while resp_valid = 1; it is 0 otherwise.
- resp_valid lasts exactly one cycle and has no back-pressure; the consumer must take it.
- mem_pc = latched req_pc while busy.
- Reset mid-operation: the transaction is aborted and no response is produced. After an abort in ACC1, the ACC0 half of a store remains written and the ACC1 half is never written.
- req_valid asserted while busy: ignored. The requester must hold it until req_ready.

Test Plan:
- lw addr 0x10, word@0x10 = 0x11223344 -> one access at 0x10, strb 0000, resp_valid 2 cycles after accept, rdata 0x11223344, fault 0.
- lh addr 0x13, word@0x10 = 0xAABBCCDD, word@0x14 = 0x112233F4 -> accesses 0x10 then 0x14, resp 3 cycles after accept, rdata 0xFFFFF4AA; same request with lhu -> 0x0000F4AA.
- sw 0xDEADBEEF at 0x22:
  - ACC0: addr 0x20, strb 1100, wdata 0xBEEF0000.
  - ACC1: addr 0x24, strb 0011, wdata 0x0000DEAD.
  - Readback lw 0x22 -> 0xDEADBEEF.
- lb/lbu at 0x01, word@0x00 = 0x00008000 -> 0xFFFFFF80 / 0x00000080; sb 0x5A at 0x03 -> strb 1000, wdata 0x5A000000, single access.
- Load funct3 = 3 at 0x40 -> resp_valid in cycle after accept, resp_fault 1, rdata 0, mem_we never high. With MISALIGN_TRAP = 1, sw at 0x02 -> fault, no write.
- Split sw at 0xFFFFFFFE, rst asserted during ACC1:
  - Before reset: ACC0 address 0xFFFFFFFC; the ACC1 address would have wrapped to 0x00000000.
  - mem_we falls in the same cycle as rst.
  - No resp_valid.
  - Word 0x00000000 unchanged.
  - req_ready = 1 after rst drops.
